// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: scales each DDS sample by an 8-bit level that
// ramps through attack/decay/sustain/release under note start/release pulses.
module adsr_envelope #(
    parameter int unsigned ATTACK_DIV  = 48,
    parameter int unsigned DECAY_DIV   = 96,
    parameter int unsigned RELEASE_DIV = 192,
    parameter logic [7:0]  SUSTAIN_LVL = 8'd160
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        note_start,
    input  logic        note_release,
    input  logic [15:0] sample,
    input  logic        new_sample_ready,
    output logic [15:0] env_sample,
    output logic        env_sample_ready,
    output logic [7:0]  level,
    output logic        busy
);

    localparam int unsigned MAX_AD  = (ATTACK_DIV > DECAY_DIV) ? ATTACK_DIV : DECAY_DIV;
    localparam int unsigned MAX_DIV = (MAX_AD > RELEASE_DIV) ? MAX_AD : RELEASE_DIV;
    localparam int unsigned CNT_W   = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

    localparam logic [CNT_W-1:0] ATTACK_LAST  = CNT_W'(ATTACK_DIV - 1);
    localparam logic [CNT_W-1:0] DECAY_LAST   = CNT_W'(DECAY_DIV - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        DECAY,
        SUSTAIN,
        RELEASE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [7:0]         level_next;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic [CNT_W-1:0]   step_last;
    logic               at_step;
    logic signed [23:0] product;
    logic [15:0]        env_next;

    // Signed 16 x unsigned 8 scaling; the magnitude fits in 24 bits, and the
    // arithmetic shift gives floor rounding of the /256.
    always_comb begin
        product  = $signed(sample) * $signed({1'b0, level});
        env_next = 16'(product >>> 8);
    end

    // Envelope next-state: divider stepping, level ramps and note pulses.
    always_comb begin
        state_next = state;
        level_next = level;
        count_next = count;
        step_last  = '0;
        at_step    = 1'b0;

        case (state)
            ATTACK:  step_last = ATTACK_LAST;
            DECAY:   step_last = DECAY_LAST;
            RELEASE: step_last = RELEASE_LAST;
            default: step_last = '0;
        endcase
        at_step = new_sample_ready && (count == step_last);

        if (note_start) begin
            state_next = ATTACK;
        end else if (note_release &&
                     (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
            state_next = RELEASE;
        end else begin
            case (state)
                IDLE: begin
                    level_next = '0;
                end
                ATTACK: begin
                    if (at_step) begin
                        count_next = '0;
                        if (level != 8'hFF) begin
                            level_next = level + 8'd1;
                        end
                        // A step that lands on (or is already at) full scale ends attack.
                        if (level >= 8'hFE) begin
                            state_next = DECAY;
                        end
                    end else if (new_sample_ready) begin
                        count_next = count + CNT_W'(1);
                    end
                end
                DECAY: begin
                    // Covers SUSTAIN_LVL = 255: decay is left immediately without a step.
                    if (level <= SUSTAIN_LVL) begin
                        state_next = SUSTAIN;
                    end else if (at_step) begin
                        count_next = '0;
                        level_next = level - 8'd1;
                        if (level_next == SUSTAIN_LVL) begin
                            state_next = SUSTAIN;
                        end
                    end else if (new_sample_ready) begin
                        count_next = count + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (level == 8'd0) begin
                        state_next = IDLE;
                    end else if (at_step) begin
                        count_next = '0;
                        level_next = level - 8'd1;
                        if (level == 8'd1) begin
                            state_next = IDLE;
                        end
                    end else if (new_sample_ready) begin
                        count_next = count + CNT_W'(1);
                    end
                end
                default: begin
                    level_next = level;
                end
            endcase
        end

        if (note_start || (state_next != state)) begin
            count_next = '0;
        end
    end

    // Envelope state register; busy is registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            level <= '0;
            count <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            level <= level_next;
            count <= count_next;
            busy  <= (state_next != IDLE);
        end
    end

    // Output sample register: one-cycle latency, holds between strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            env_sample       <= '0;
            env_sample_ready <= 1'b0;
        end else begin
            env_sample_ready <= new_sample_ready;
            if (new_sample_ready) begin
                env_sample <= env_next;
            end
        end
    end

endmodule

// File: tb/tb_adsr_envelope.sv
// Bench for adsr_envelope: three differently parameterised instances share
// one stimulus stream and are compared every cycle against an integer model.
module tb_adsr_envelope;

    localparam int P_IDLE = 0;
    localparam int P_ATK  = 1;
    localparam int P_DEC  = 2;
    localparam int P_SUS  = 3;
    localparam int P_REL  = 4;

    logic        clk;
    logic        reset;
    logic        note_start;
    logic        note_release;
    logic [15:0] sample;
    logic        new_sample_ready;

    logic [15:0] env_s [3];
    logic        rdy_s [3];
    logic [7:0]  lvl_s [3];
    logic        bsy_s [3];

    int adiv [3] = '{2, 3, 1};
    int ddiv [3] = '{1, 2, 3};
    int rdiv [3] = '{1, 3, 2};
    int sus  [3] = '{250, 255, 0};

    int m_ph  [3];
    int m_lvl [3];
    int m_cnt [3];
    int m_out [3];
    int m_rdy [3];

    int n_checks = 0;
    int n_errors = 0;

    adsr_envelope #(.ATTACK_DIV(2), .DECAY_DIV(1), .RELEASE_DIV(1), .SUSTAIN_LVL(8'd250)) u0 (
        .clk(clk), .reset(reset), .note_start(note_start), .note_release(note_release),
        .sample(sample), .new_sample_ready(new_sample_ready),
        .env_sample(env_s[0]), .env_sample_ready(rdy_s[0]), .level(lvl_s[0]), .busy(bsy_s[0]));

    adsr_envelope #(.ATTACK_DIV(3), .DECAY_DIV(2), .RELEASE_DIV(3), .SUSTAIN_LVL(8'd255)) u1 (
        .clk(clk), .reset(reset), .note_start(note_start), .note_release(note_release),
        .sample(sample), .new_sample_ready(new_sample_ready),
        .env_sample(env_s[1]), .env_sample_ready(rdy_s[1]), .level(lvl_s[1]), .busy(bsy_s[1]));

    adsr_envelope #(.ATTACK_DIV(1), .DECAY_DIV(3), .RELEASE_DIV(2), .SUSTAIN_LVL(8'd0)) u2 (
        .clk(clk), .reset(reset), .note_start(note_start), .note_release(note_release),
        .sample(sample), .new_sample_ready(new_sample_ready),
        .env_sample(env_s[2]), .env_sample_ready(rdy_s[2]), .level(lvl_s[2]), .busy(bsy_s[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference envelope: level counts strobes against the phase divider,
    // output is floor(sample * level / 256) using the level before the edge.
    task automatic model_step(input int i, input logic r, input logic s, input logic n,
                              input logic st, input logic [15:0] smp);
        int nph;
        if (r) begin
            m_ph[i] = P_IDLE; m_lvl[i] = 0; m_cnt[i] = 0; m_out[i] = 0; m_rdy[i] = 0;
            return;
        end
        m_rdy[i] = st ? 1 : 0;
        if (st) m_out[i] = (int'($signed(smp)) * m_lvl[i]) >>> 8;
        nph = m_ph[i];
        if (s) begin
            nph = P_ATK;
        end else if (n && (m_ph[i] == P_ATK || m_ph[i] == P_DEC || m_ph[i] == P_SUS)) begin
            nph = P_REL;
        end else if (m_ph[i] == P_ATK) begin
            if (st) begin
                m_cnt[i] = m_cnt[i] + 1;
                if (m_cnt[i] == adiv[i]) begin
                    m_cnt[i] = 0;
                    if (m_lvl[i] < 255) m_lvl[i] = m_lvl[i] + 1;
                    if (m_lvl[i] == 255) nph = P_DEC;
                end
            end
        end else if (m_ph[i] == P_DEC) begin
            if (m_lvl[i] <= sus[i]) begin
                nph = P_SUS;
            end else if (st) begin
                m_cnt[i] = m_cnt[i] + 1;
                if (m_cnt[i] == ddiv[i]) begin
                    m_cnt[i] = 0;
                    m_lvl[i] = m_lvl[i] - 1;
                    if (m_lvl[i] == sus[i]) nph = P_SUS;
                end
            end
        end else if (m_ph[i] == P_REL) begin
            if (m_lvl[i] == 0) begin
                nph = P_IDLE;
            end else if (st) begin
                m_cnt[i] = m_cnt[i] + 1;
                if (m_cnt[i] == rdiv[i]) begin
                    m_cnt[i] = 0;
                    m_lvl[i] = m_lvl[i] - 1;
                    if (m_lvl[i] == 0) nph = P_IDLE;
                end
            end
        end
        if (s || nph != m_ph[i]) m_cnt[i] = 0;
        m_ph[i] = nph;
    endtask

    task automatic cycle(input logic r, input logic s, input logic n,
                         input logic st, input logic [15:0] smp);
        reset = r; note_start = s; note_release = n; new_sample_ready = st; sample = smp;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i, r, s, n, st, smp);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("level%0d", i), 32'(lvl_s[i]), 32'(m_lvl[i]));
            check_eq($sformatf("busy%0d", i), 32'(bsy_s[i]), (m_ph[i] != P_IDLE) ? 32'd1 : 32'd0);
            check_eq($sformatf("ready%0d", i), 32'(rdy_s[i]), 32'(m_rdy[i]));
            check_eq($sformatf("env%0d", i), 32'(env_s[i]), 32'(m_out[i]) & 32'h0000FFFF);
        end
    endtask

    task automatic strobes(input int cnt, input logic [15:0] smp);
        for (int k = 0; k < cnt; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1, smp);
    endtask

    initial begin
        reset = 1'b1; note_start = 1'b0; note_release = 1'b0;
        new_sample_ready = 1'b0; sample = '0;

        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        check_eq("rst_level", 32'(lvl_s[0]), 32'd0);
        check_eq("rst_busy", 32'(bsy_s[0]), 32'd0);
        check_eq("rst_ready", 32'(rdy_s[0]), 32'd0);

        // Strobes while idle: output pulses with zero data.
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h4000);
            check_eq("idle_ready", 32'(rdy_s[0]), 32'd1);
            check_eq("idle_env", 32'(env_s[0]), 32'd0);
            check_eq("idle_busy", 32'(bsy_s[0]), 32'd0);
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h4000);
            check_eq("idle_ready_gap", 32'(rdy_s[0]), 32'd0);
        end

        // Full attack and decay to sustain.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        check_eq("start_busy", 32'(bsy_s[0]), 32'd1);
        strobes(509, 16'h1234);
        check_eq("atk_509", 32'(lvl_s[0]), 32'd254);
        strobes(1, 16'h1234);
        check_eq("atk_peak", 32'(lvl_s[0]), 32'd255);
        strobes(5, 16'h1234);
        check_eq("decay_sus", 32'(lvl_s[0]), 32'd250);
        strobes(260, 16'h1234);
        check_eq("sus_hold", 32'(lvl_s[0]), 32'd250);
        check_eq("sus255_lvl", 32'(lvl_s[1]), 32'd255);

        // Scaling at full scale (instance sustaining at 255).
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h7FFF);
        check_eq("scale_7fff", 32'(env_s[1]), 32'h7F7F);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h8000);
        check_eq("scale_8000", 32'(env_s[1]), 32'h8080);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
        check_eq("scale_ffff", 32'(env_s[1]), 32'hFFFF);

        // Release from 250 to idle, one step per strobe.
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        for (int k = 1; k <= 250; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h4000);
            if (251 - k == 128) check_eq("scale_128", 32'(env_s[0]), 32'h2000);
            if (k == 249) check_eq("rel_busy_hi", 32'(bsy_s[0]), 32'd1);
        end
        check_eq("rel_level0", 32'(lvl_s[0]), 32'd0);
        check_eq("rel_busy_lo", 32'(bsy_s[0]), 32'd0);

        // Retrigger during release with simultaneous release pulse.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        strobes(201, 16'h0100);
        check_eq("atk_100", 32'(lvl_s[0]), 32'd100);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        check_eq("retrig_lvl", 32'(lvl_s[0]), 32'd100);
        strobes(1, 16'h0100);
        check_eq("retrig_cnt", 32'(lvl_s[0]), 32'd100);
        strobes(1, 16'h0100);
        check_eq("retrig_step", 32'(lvl_s[0]), 32'd101);

        // Reset in the same cycle as a strobe during attack.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        strobes(80, 16'h4000);
        check_eq("atk_40", 32'(lvl_s[0]), 32'd40);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h4000);
        check_eq("mid_rst_level", 32'(lvl_s[0]), 32'd0);
        check_eq("mid_rst_busy", 32'(bsy_s[0]), 32'd0);
        check_eq("mid_rst_env", 32'(env_s[0]), 32'd0);
        check_eq("mid_rst_ready", 32'(rdy_s[0]), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);

        // Randomised note and strobe traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 499) == 0),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 1) == 0),
                  16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adsr_envelope.md
# adsr_envelope

Amplitude-envelope stage directly downstream of the DDS sine generator in the music player. It takes each 16-bit signed DDS sample, marked by the DDS `new_sample_ready` strobe, and scales it by an 8-bit envelope level. The level follows an attack/decay/sustain/release state machine driven by note start/release pulses from the note player. The block emits a shaped sample with its own ready strobe for the codec/mixer path.

## Interface
- `ATTACK_DIV`, default 48: samples per +1 level step in ATTACK (≥1)
- `DECAY_DIV`, default 96: samples per −1 level step in DECAY (≥1)
- `RELEASE_DIV`, default 192: samples per −1 level step in RELEASE (≥1)
- `SUSTAIN_LVL`, default 8'd160: sustain level (0..255)
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high reset
- `note_start` in 1: one-cycle pulse; begin or retrigger a note
- `note_release` in 1: one-cycle pulse; key released
- `sample` in 16: signed DDS sample
- `new_sample_ready` in 1: one-cycle strobe; `sample` is valid this cycle
- `env_sample` out 16: signed shaped sample
- `env_sample_ready` out 1: one-cycle strobe; `env_sample` updated
- `level` out 8: current envelope level, unsigned
- `busy` out 1: high whenever state ≠ IDLE

One clock; reset is synchronous and active-high.

## Operation
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. On reset: state IDLE, `level`=0, step counter 0, `env_sample`=0, `env_sample_ready`=0, `busy`=0.
- Step counter counts `new_sample_ready` strobes from 0 to DIV−1 for the current state's divider. A strobe arriving when count = DIV−1 is a "step": the counter goes to 0 and the level is updated. The counter clears on `note_start` and on every state change. It holds in IDLE and SUSTAIN.
- IDLE: level stays 0. `note_start` moves to ATTACK.
- ATTACK: a step does level+1. A step that makes level 255 also moves to DECAY.
- DECAY: a step does level−1. When level reaches SUSTAIN_LVL, move to SUSTAIN. If SUSTAIN_LVL=255, DECAY lasts exactly one cycle with no level change, then SUSTAIN.
- SUSTAIN: level held.
- RELEASE: a step does level−1. A step that makes level 0 also moves to IDLE. Entering RELEASE with level 0 goes to IDLE on the next cycle.
- `note_release` in ATTACK, DECAY or SUSTAIN moves to RELEASE from the current level. It is ignored in IDLE and RELEASE.
- `note_start` in any state moves to ATTACK. The level is not reset; attack ramps from the current level (click-free retrigger). If `note_start` and `note_release` are high in the same cycle, `note_start` wins.
- Level never wraps: it saturates at 0 and 255 in all states.
- Scaling: product = signed(sample) × {1'b0, level}, a 25-bit signed value. `env_sample` = product[23:8]. This is an arithmetic shift right by 8 with floor rounding. Level 0 always gives 0.

## Timing
- `env_sample` and `env_sample_ready` are registered on the clock edge after the `new_sample_ready` cycle. Latency is 1 cycle.
- The scaling uses the `level` value present in the strobe cycle, before any step update made on that same edge.
- `env_sample_ready` is high for exactly one cycle per input strobe, including in IDLE (output 0). `env_sample` holds between strobes.
- Back-to-back strobes on consecutive cycles are accepted with no loss.
- `busy` and `level` are registered and change on the edge where the state or level changes.
- `reset` asserted mid-note returns all outputs to reset values on the next edge. A strobe in the reset cycle is dropped (`env_sample_ready` stays 0).

## Test plan
- Reset, then strobes with `sample`=16'h4000 in IDLE. Required: `env_sample_ready` pulses 1 cycle after each strobe, `env_sample`=0, `busy`=0, `level`=0.
- ATTACK_DIV=2, DECAY_DIV=1, SUSTAIN_LVL=250. `note_start`, then continuous strobes. Required: level +1 every 2nd strobe, reaching 255 after 510 strobes. It then decrements 1 per strobe to 250 (SUSTAIN) after 5 more strobes and holds.
- Scaling at level 255. Required: `sample`=16'h7FFF gives 16'h7F7F; `sample`=16'h8000 gives 16'h8080; `sample`=16'hFFFF gives 16'hFFFF. At level 128, `sample`=16'h4000 gives 16'h2000.
- In SUSTAIN at level 250 with RELEASE_DIV=1, pulse `note_release`. Required: level falls 1 per strobe, reaching 0 after 250 strobes. `busy` drops on the edge where level reaches 0, and the state is IDLE.
- Mid-RELEASE at level 100, assert `note_start` and `note_release` in the same cycle. Required: state ATTACK, level resumes +1 steps from 100, counter restarted.
- Mid-ATTACK at level 40, assert `reset` in the same cycle as a strobe. Required: on the next edge `level`=0, `busy`=0, `env_sample`=0, and no `env_sample_ready` pulse.
